// File: rtl/pipe_hazard_ctrl.sv
// Per-stage hold/flush and PC redirect for an in-order pipeline; outputs are combinational (0 cycles), with state updating at the next edge.
// No backpressure: requests are served by priority each cycle. CTRL_PERF_CNT_EN adds stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int EX_STAGE  = 2,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 4,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_hold_req_i,
  input  logic [CNT_W-1:0]  ex_hold_cnt_i,
  input  logic              ld_use_i,
  input  logic              prd_jump_en_i,
  input  logic              ex_valid_i,
  input  logic              ex_jump_en_i,
  input  logic              id_ex_jump_en_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic [ADDR_W-1:0] ex_pc_next_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  output logic [STAGES-1:0] hold_en_o,
  output logic [STAGES-1:0] flush_en_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              busy_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [STAGES-1:0] ONE      = STAGES'(1);
  localparam logic [STAGES-1:0] TRAP_FL  = ~ONE;
  localparam logic [STAGES-1:0] PF_FL    = ((ONE << (EX_STAGE + 1)) - ONE) & ~ONE;
  localparam logic [STAGES-1:0] EXH_HOLD = (ONE << (EX_STAGE + 1)) - ONE;
  localparam logic [STAGES-1:0] EXH_FL   = ONE << (EX_STAGE + 1);
  localparam logic [STAGES-1:0] LU_HOLD  = (ONE << EX_STAGE) - ONE;
  localparam logic [STAGES-1:0] LU_FL    = ONE << EX_STAGE;
  localparam logic [STAGES-1:0] PJ_FL    = ONE << 1;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  eff_cnt;
  logic [FW-1:0]     win;
  logic [STAGES-1:0] fl_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] flush;
  logic              redir;
  logic [ADDR_W-1:0] raddr;
  logic              prd_fail;
  logic [ADDR_W-1:0] target;

  assign prd_fail = ex_valid_i & (ex_jump_en_i != id_ex_jump_en_i);
  assign target   = ex_jump_en_i ? ex_jump_addr_i : ex_pc_next_i;
  assign eff_cnt  = (ex_hold_cnt_i == '0) ? CNT_W'(1) : ex_hold_cnt_i;

  // A trap wins in every state; STALL and FLUSH otherwise ignore new requests.
  always_comb begin
    hold  = '0;
    flush = '0;
    redir = 1'b0;
    raddr = addr_lat;
    if (trap_req_i) begin
      flush = TRAP_FL;
      redir = 1'b1;
      raddr = trap_addr_i;
    end else begin
      case (state)
        RUN: begin
          if (prd_fail) begin
            flush = PF_FL;
            redir = 1'b1;
            raddr = target;
          end else if (ex_hold_req_i) begin
            hold  = EXH_HOLD;
            flush = EXH_FL;
          end else if (ld_use_i) begin
            hold  = LU_HOLD;
            flush = LU_FL;
          end else if (prd_jump_en_i) begin
            flush = PJ_FL;
          end
        end
        STALL: begin
          hold  = EXH_HOLD;
          flush = EXH_FL;
        end
        FLUSH:   flush = fl_lat;
        default: flush = '0;
      endcase
    end
  end

  assign hold_en_o       = rstn ? (hold & ~flush) : '0;
  assign flush_en_o      = rstn ? (flush & ~ONE) : '0;
  assign redirect_o      = rstn & redir;
  assign redirect_addr_o = rstn ? raddr : '0;
  assign busy_o          = rstn & (state != RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      cnt      <= '0;
      win      <= '0;
      fl_lat   <= '0;
      addr_lat <= '0;
    end else if (redir) begin
      addr_lat <= raddr;
      fl_lat   <= flush;
      cnt      <= '0;
      if (FLUSH_CYC > 1) begin
        state <= FLUSH;
        win   <= FW'(FLUSH_CYC - 1);
      end else begin
        state <= RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (ex_hold_req_i && (eff_cnt > CNT_W'(1))) begin
            cnt   <= eff_cnt - CNT_W'(1);
            state <= STALL;
          end
        end
        STALL: begin
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (win <= FW'(1)) state <= RUN;
          else               win   <= win - FW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Every trap or mispredict event redirects exactly once, so redirect_o marks the events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(hold_en_o[0]);
      flush_cnt <= flush_cnt + 32'(redirect_o);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FLUSH_CYC 1 and 2) share stimulus and are checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int S  = 5;
  localparam int EX = 2;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ex_hold_req, ld_use, prd_jump_en, ex_valid, ex_jump_en, id_ex_jump_en, trap_req;
  logic [CW-1:0] ex_hold_cnt;
  logic [AW-1:0] ex_jump_addr, ex_pc_next, trap_addr;

  logic [S-1:0]  o_hold[2];
  logic [S-1:0]  o_flush[2];
  logic          o_redir[2];
  logic          o_busy[2];
  logic [AW-1:0] o_addr[2];
  logic [31:0]   o_sc[2];
  logic [31:0]   o_fc[2];

  int n_vec = 0;
  int n_err = 0;

  // Model state: cycles still to run in a stall or flush window after the current one.
  int            stall_rem[2];
  int            flush_rem[2];
  logic [S-1:0]  lat_fl[2];
  logic [31:0]   perf_s[2];
  logic [31:0]   perf_f[2];
  logic [S-1:0]  e_hold[2];
  logic [S-1:0]  e_flush[2];
  logic          e_redir[2];
  logic [AW-1:0] e_addr[2];
  logic          e_busy[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STAGES(S), .EX_STAGE(EX), .ADDR_W(AW), .CNT_W(CW), .FLUSH_CYC(1)) dut (
    .clk(clk), .rstn(rstn), .ex_hold_req_i(ex_hold_req), .ex_hold_cnt_i(ex_hold_cnt),
    .ld_use_i(ld_use), .prd_jump_en_i(prd_jump_en), .ex_valid_i(ex_valid),
    .ex_jump_en_i(ex_jump_en), .id_ex_jump_en_i(id_ex_jump_en), .ex_jump_addr_i(ex_jump_addr),
    .ex_pc_next_i(ex_pc_next), .trap_req_i(trap_req), .trap_addr_i(trap_addr),
    .hold_en_o(o_hold[0]), .flush_en_o(o_flush[0]), .redirect_o(o_redir[0]),
    .redirect_addr_o(o_addr[0]), .busy_o(o_busy[0]), .stall_cnt_o(o_sc[0]), .flush_cnt_o(o_fc[0]));

  pipe_hazard_ctrl #(.STAGES(S), .EX_STAGE(EX), .ADDR_W(AW), .CNT_W(CW), .FLUSH_CYC(2)) dut2 (
    .clk(clk), .rstn(rstn), .ex_hold_req_i(ex_hold_req), .ex_hold_cnt_i(ex_hold_cnt),
    .ld_use_i(ld_use), .prd_jump_en_i(prd_jump_en), .ex_valid_i(ex_valid),
    .ex_jump_en_i(ex_jump_en), .id_ex_jump_en_i(id_ex_jump_en), .ex_jump_addr_i(ex_jump_addr),
    .ex_pc_next_i(ex_pc_next), .trap_req_i(trap_req), .trap_addr_i(trap_addr),
    .hold_en_o(o_hold[1]), .flush_en_o(o_flush[1]), .redirect_o(o_redir[1]),
    .redirect_addr_o(o_addr[1]), .busy_o(o_busy[1]), .stall_cnt_o(o_sc[1]), .flush_cnt_o(o_fc[1]));

  function automatic logic [S-1:0] rng(int lo, int hi);
    logic [S-1:0] v = '0;
    for (int i = 0; i < S; i++) v[i] = (i >= lo) && (i <= hi);
    return v;
  endfunction

  task automatic idle();
    ex_hold_req = 0; ex_hold_cnt = '0; ld_use = 0; prd_jump_en = 0; ex_valid = 0;
    ex_jump_en = 0; id_ex_jump_en = 0; trap_req = 0;
    ex_jump_addr = '0; ex_pc_next = '0; trap_addr = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      stall_rem[k] = 0; flush_rem[k] = 0; lat_fl[k] = '0; perf_s[k] = '0; perf_f[k] = '0;
    end
  endtask

  task automatic model_eval();
    logic pf;
    pf = ex_valid && (ex_jump_en != id_ex_jump_en);
    for (int k = 0; k < 2; k++) begin
      e_hold[k] = '0; e_flush[k] = '0; e_redir[k] = 0; e_addr[k] = '0;
      e_busy[k] = rstn && (stall_rem[k] > 0 || flush_rem[k] > 0);
      if (!rstn) continue;
      if (trap_req) begin
        e_flush[k] = rng(1, S - 1); e_redir[k] = 1; e_addr[k] = trap_addr;
      end else if (flush_rem[k] > 0) begin
        e_flush[k] = lat_fl[k];
      end else if (stall_rem[k] > 0) begin
        e_hold[k] = rng(0, EX); e_flush[k] = rng(EX + 1, EX + 1);
      end else if (pf) begin
        e_flush[k] = rng(1, EX); e_redir[k] = 1;
        e_addr[k] = ex_jump_en ? ex_jump_addr : ex_pc_next;
      end else if (ex_hold_req) begin
        e_hold[k] = rng(0, EX); e_flush[k] = rng(EX + 1, EX + 1);
      end else if (ld_use) begin
        e_hold[k] = rng(0, EX - 1); e_flush[k] = rng(EX, EX);
      end else if (prd_jump_en) begin
        e_flush[k] = rng(1, 1);
      end
    end
  endtask

  task automatic model_commit();
    int eff;
    eff = (ex_hold_cnt == 0) ? 1 : int'(ex_hold_cnt);
    for (int k = 0; k < 2; k++) begin
      perf_s[k] = perf_s[k] + 32'(e_hold[k][0]);
      if (e_redir[k]) begin
        perf_f[k] = perf_f[k] + 1;
        lat_fl[k] = e_flush[k]; flush_rem[k] = k; stall_rem[k] = 0;
      end else if (flush_rem[k] > 0) flush_rem[k]--;
      else if (stall_rem[k] > 0) stall_rem[k]--;
      else if (ex_hold_req) stall_rem[k] = eff - 1;
    end
  endtask

  task automatic step_begin();
    #2;
    model_eval();
  endtask

  task automatic step_end();
    if (rstn) model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    ex_hold_req = 1; ex_hold_cnt = 4'd7; ld_use = 1; prd_jump_en = 1; ex_valid = 1;
    ex_jump_en = 1; id_ex_jump_en = 0; trap_req = 1; trap_addr = 32'h1234; ex_jump_addr = 32'h80;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_hold[k] !== '0) begin n_err++; $display("FAIL reset_hold[%0d]: got %b want 0", k, o_hold[k]); end
      n_vec++; if (o_flush[k] !== '0) begin n_err++; $display("FAIL reset_flush[%0d]: got %b want 0", k, o_flush[k]); end
      n_vec++; if (o_redir[k] !== 1'b0) begin n_err++; $display("FAIL reset_redir[%0d]: got %b want 0", k, o_redir[k]); end
      n_vec++; if (o_addr[k] !== '0) begin n_err++; $display("FAIL reset_addr[%0d]: got %h want 0", k, o_addr[k]); end
    end
    @(posedge clk); #1;
    idle();
    rstn = 1;
    step_begin();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_busy[k] !== 1'b0) begin n_err++; $display("FAIL post_reset_busy[%0d]: got %b want 0", k, o_busy[k]); end
      n_vec++; if (o_sc[k] !== 32'd0 || o_fc[k] !== 32'd0) begin n_err++; $display("FAIL post_reset_cnt[%0d]: got %0d/%0d want 0/0", k, o_sc[k], o_fc[k]); end
    end
    step_end();
  endtask

  task automatic test_ex_hold();
    idle(); ex_hold_req = 1; ex_hold_cnt = 4'd3;
    for (int c = 0; c < 4; c++) begin
      step_begin();
      n_vec++; if (o_hold[0] !== (c < 3 ? 5'b00111 : 5'b00000)) begin n_err++; $display("FAIL ex_hold_hold c%0d: got %b", c, o_hold[0]); end
      n_vec++; if (o_flush[0] !== (c < 3 ? 5'b01000 : 5'b00000)) begin n_err++; $display("FAIL ex_hold_flush c%0d: got %b", c, o_flush[0]); end
      n_vec++; if (o_busy[0] !== (c == 1 || c == 2)) begin n_err++; $display("FAIL ex_hold_busy c%0d: got %b", c, o_busy[0]); end
      step_end();
      idle();
    end
    ex_hold_req = 1; ex_hold_cnt = 4'd0;
    step_begin();
    n_vec++; if (o_hold[0] !== 5'b00111) begin n_err++; $display("FAIL ex_hold_zero_hold: got %b want 00111", o_hold[0]); end
    step_end(); idle();
    step_begin();
    n_vec++; if (o_hold[0] !== 5'b00000 || o_busy[0] !== 1'b0) begin n_err++; $display("FAIL ex_hold_zero_end: hold %b busy %b want 0/0", o_hold[0], o_busy[0]); end
    step_end();
  endtask

  task automatic test_mispredict();
    idle(); ex_valid = 1; id_ex_jump_en = 0; ex_jump_en = 1; ex_jump_addr = 32'h80; ld_use = 1;
    step_begin();
    n_vec++; if (o_flush[0] !== 5'b00110) begin n_err++; $display("FAIL mp_flush: got %b want 00110", o_flush[0]); end
    n_vec++; if (o_hold[0] !== 5'b00000) begin n_err++; $display("FAIL mp_hold: got %b want 0", o_hold[0]); end
    n_vec++; if (o_redir[0] !== 1'b1 || o_addr[0] !== 32'h80) begin n_err++; $display("FAIL mp_redir: got %b/%h want 1/80", o_redir[0], o_addr[0]); end
    step_end(); idle();
    step_begin();
    n_vec++; if (o_flush[0] !== 5'b0 || o_redir[0] !== 1'b0 || o_busy[0] !== 1'b0) begin n_err++; $display("FAIL mp_after0: flush %b redir %b busy %b", o_flush[0], o_redir[0], o_busy[0]); end
    n_vec++; if (o_flush[1] !== 5'b00110 || o_redir[1] !== 1'b0 || o_busy[1] !== 1'b1) begin n_err++; $display("FAIL mp_after1: flush %b redir %b busy %b", o_flush[1], o_redir[1], o_busy[1]); end
    step_end();
    step_begin(); step_end();
    ex_valid = 1; id_ex_jump_en = 1; ex_jump_en = 0; ex_pc_next = 32'h44; ex_jump_addr = 32'h999;
    step_begin();
    n_vec++; if (o_redir[0] !== 1'b1 || o_addr[0] !== 32'h44) begin n_err++; $display("FAIL mp_fallthru: got %b/%h want 1/44", o_redir[0], o_addr[0]); end
    step_end(); idle();
    step_begin(); step_end();
    ld_use = 1;
    step_begin();
    n_vec++; if (o_hold[0] !== 5'b00011 || o_flush[0] !== 5'b00100) begin n_err++; $display("FAIL ld_use: hold %b flush %b want 00011/00100", o_hold[0], o_flush[0]); end
    step_end(); idle();
    step_begin();
    n_vec++; if (o_hold[0] !== 5'b0 || o_busy[0] !== 1'b0) begin n_err++; $display("FAIL ld_use_end: hold %b busy %b", o_hold[0], o_busy[0]); end
    step_end();
    prd_jump_en = 1;
    step_begin();
    n_vec++; if (o_flush[0] !== 5'b00010 || o_redir[0] !== 1'b0) begin n_err++; $display("FAIL prd_jump: flush %b redir %b want 00010/0", o_flush[0], o_redir[0]); end
    step_end(); idle();
  endtask

  task automatic test_trap_stall();
    idle(); ex_hold_req = 1; ex_hold_cnt = 4'd5;
    step_begin(); step_end(); idle();
    trap_req = 1; trap_addr = 32'h200;
    step_begin();
    n_vec++; if (o_flush[1] !== 5'b11110 || o_hold[1] !== 5'b0) begin n_err++; $display("FAIL trap_stall_vec: flush %b hold %b", o_flush[1], o_hold[1]); end
    n_vec++; if (o_redir[1] !== 1'b1 || o_addr[1] !== 32'h200) begin n_err++; $display("FAIL trap_stall_redir: got %b/%h want 1/200", o_redir[1], o_addr[1]); end
    step_end(); idle();
    step_begin();
    n_vec++; if (o_flush[1] !== 5'b11110 || o_redir[1] !== 1'b0 || o_busy[1] !== 1'b1) begin n_err++; $display("FAIL trap_win: flush %b redir %b busy %b", o_flush[1], o_redir[1], o_busy[1]); end
    n_vec++; if (o_flush[0] !== 5'b0 || o_busy[0] !== 1'b0) begin n_err++; $display("FAIL trap_fc1_done: flush %b busy %b", o_flush[0], o_busy[0]); end
    step_end();
    step_begin();
    n_vec++; if (o_flush[1] !== 5'b0 || o_hold[1] !== 5'b0 || o_busy[1] !== 1'b0) begin n_err++; $display("FAIL trap_run: flush %b hold %b busy %b", o_flush[1], o_hold[1], o_busy[1]); end
    step_end();
  endtask

  task automatic test_async_reset();
    idle(); ex_hold_req = 1; ex_hold_cnt = 4'd6;
    step_begin(); step_end(); idle();
    #3 rstn = 0;
    #1;
    n_vec++; if (o_busy[0] !== 1'b0 || o_hold[0] !== 5'b0) begin n_err++; $display("FAIL async_rst: busy %b hold %b want 0/0", o_busy[0], o_hold[0]); end
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    step_begin();
    n_vec++; if (o_busy[0] !== 1'b0 || o_hold[0] !== 5'b0) begin n_err++; $display("FAIL async_rst_run: busy %b hold %b", o_busy[0], o_hold[0]); end
    step_end();
  endtask

  task automatic test_perf();
    logic [31:0] ws, wf;
    rstn = 0; idle(); model_reset();
    @(posedge clk); #1; rstn = 1;
    ex_hold_req = 1; ex_hold_cnt = 4'd3;
    step_begin(); step_end(); idle();
    step_begin(); step_end();
    step_begin(); step_end();
    ex_valid = 1; ex_jump_en = 1; ex_jump_addr = 32'h80;
    step_begin(); step_end(); idle();
    step_begin(); step_end();
`ifdef CTRL_PERF_CNT_EN
    ws = 32'd3; wf = 32'd1;
`else
    ws = 32'd0; wf = 32'd0;
`endif
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_sc[k] !== ws || o_fc[k] !== wf) begin n_err++; $display("FAIL perf[%0d]: got %0d/%0d want %0d/%0d", k, o_sc[k], o_fc[k], ws, wf); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ws, wf;
    for (int c = 0; c < 1500; c++) begin
      trap_req      = ($urandom_range(0, 19) == 0);
      trap_addr     = $urandom;
      ex_hold_req   = ($urandom_range(0, 7) == 0);
      ex_hold_cnt   = CW'($urandom_range(0, 15));
      ld_use        = ($urandom_range(0, 3) == 0);
      prd_jump_en   = ($urandom_range(0, 3) == 0);
      ex_valid      = ($urandom_range(0, 1) == 0);
      ex_jump_en    = ($urandom_range(0, 1) == 0);
      id_ex_jump_en = ($urandom_range(0, 2) != 0) ? ex_jump_en : !ex_jump_en;
      ex_jump_addr  = $urandom;
      ex_pc_next    = $urandom;
      step_begin();
      for (int k = 0; k < 2; k++) begin
`ifdef CTRL_PERF_CNT_EN
        ws = perf_s[k]; wf = perf_f[k];
`else
        ws = '0; wf = '0;
`endif
        n_vec++; if (o_hold[k] !== e_hold[k]) begin n_err++; $display("FAIL rnd_hold[%0d] c%0d: got %b want %b", k, c, o_hold[k], e_hold[k]); end
        n_vec++; if (o_flush[k] !== e_flush[k]) begin n_err++; $display("FAIL rnd_flush[%0d] c%0d: got %b want %b", k, c, o_flush[k], e_flush[k]); end
        n_vec++; if (o_redir[k] !== e_redir[k]) begin n_err++; $display("FAIL rnd_redir[%0d] c%0d: got %b want %b", k, c, o_redir[k], e_redir[k]); end
        n_vec++; if (o_busy[k] !== e_busy[k]) begin n_err++; $display("FAIL rnd_busy[%0d] c%0d: got %b want %b", k, c, o_busy[k], e_busy[k]); end
        if (e_redir[k]) begin
          n_vec++; if (o_addr[k] !== e_addr[k]) begin n_err++; $display("FAIL rnd_addr[%0d] c%0d: got %h want %h", k, c, o_addr[k], e_addr[k]); end
        end
        n_vec++; if (o_sc[k] !== ws || o_fc[k] !== wf) begin n_err++; $display("FAIL rnd_perf[%0d] c%0d: got %0d/%0d want %0d/%0d", k, c, o_sc[k], o_fc[k], ws, wf); end
      end
      step_end();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ex_hold();
    test_mispredict();
    test_trap_stall();
    test_async_reset();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
